// File: rtl/bus_arbiter.sv
// ============================================================================
// bus_arbiter : two-port arbiter sharing one wait-stated memory bus
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int AW   = 13,
    parameter int DW   = 8,
    parameter int WAIT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          cpu_halt,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [2:0] WAIT_CNT = 3'(WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       winner;
    logic       last_served;
    logic       wr_lat;
    logic [2:0] wait_cnt;
    logic       sel;
    logic       any_req;

    // Ties go to the loader while the CPU is halted, otherwise alternate.
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            sel = cpu_halt ? 1'b1 : ~last_served;
        end else begin
            sel = req1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_cnt == 3'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            winner      <= 1'b0;
            last_served <= 1'b1;
            wr_lat      <= 1'b0;
            wait_cnt    <= 3'd0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata0      <= '0;
            rdata1      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        winner    <= sel;
                        wr_lat    <= sel ? wr1 : wr0;
                        mem_addr  <= sel ? addr1 : addr0;
                        mem_wdata <= sel ? wdata1 : wdata0;
                        wait_cnt  <= WAIT_CNT;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else if (!wr_lat) begin
                        // Final access edge: memory data is valid now.
                        if (winner) begin
                            rdata1 <= mem_rdata;
                        end else begin
                            rdata0 <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    last_served <= winner;
                end
                default: begin
                    wait_cnt <= 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        busy   = (state != IDLE);
        gnt0   = busy && !winner;
        gnt1   = busy && winner;
        done0  = (state == RESP) && !winner;
        done1  = (state == RESP) && winner;
        mem_rd = (state == ACCESS) && !wr_lat;
        mem_wr = (state == ACCESS) && wr_lat;
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// tb_bus_arbiter : directed scenarios plus randomized run against a
//                  transaction-level reference model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    localparam int AW   = 13;
    localparam int DW   = 8;
    localparam int WAIT = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, wr0, wr1, cpu_halt;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1, mem_rdata;
    logic          gnt0, gnt1, done0, done1, mem_rd, mem_wr, busy;
    logic [DW-1:0] rdata0, rdata1, mem_wdata;
    logic [AW-1:0] mem_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .cpu_halt(cpu_halt),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Mutual-exclusion monitor runs for the whole simulation.
    always @(negedge clk) begin
        if ((gnt0 && gnt1) || (done0 && done1) || (mem_rd && mem_wr)) begin
            failures++;
            $display("FAIL exclusivity: gnt=%b%b done=%b%b rd/wr=%b%b required no overlap",
                     gnt0, gnt1, done0, done1, mem_rd, mem_wr);
        end
    end

    task automatic drive_idle();
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; cpu_halt = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        drive_idle();
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 0;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, done0, done1, mem_rd, mem_wr, busy, mem_addr, mem_wdata, rdata0, rdata1} !== '0) begin
            failures++;
            $display("FAIL reset_state: gnt=%b%b done=%b%b rd=%b wr=%b busy=%b addr=%h wd=%h r0=%h r1=%h required all 0",
                     gnt0, gnt1, done0, done1, mem_rd, mem_wr, busy, mem_addr, mem_wdata, rdata0, rdata1);
        end
        reset = 1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_read();
        req0 = 1; wr0 = 0; addr0 = 13'h0005; mem_rdata = 8'hA5;
        for (int c = 1; c <= WAIT + 1; c++) begin
            @(negedge clk);
            checks++;
            if ({gnt0, gnt1, mem_rd, mem_wr, done0, busy} !== 6'b101001 || mem_addr !== 13'h0005) begin
                failures++;
                $display("FAIL read_access_c%0d: gnt=%b%b rd=%b wr=%b done0=%b busy=%b addr=%h required 101001 addr 0005",
                         c, gnt0, gnt1, mem_rd, mem_wr, done0, busy, mem_addr);
            end
        end
        @(negedge clk);
        checks++;
        if ({gnt0, done0, mem_rd} !== 3'b110) begin
            failures++;
            $display("FAIL read_done: gnt0=%b done0=%b rd=%b required 110", gnt0, done0, mem_rd);
        end
        checks++;
        if (rdata0 !== 8'hA5) begin
            failures++;
            $display("FAIL read_data: rdata0=%h required a5", rdata0);
        end
        req0 = 0; mem_rdata = 8'h00;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt0 !== 1'b0 || rdata0 !== 8'hA5) begin
            failures++;
            $display("FAIL read_after: busy=%b gnt0=%b rdata0=%h required 0 0 a5", busy, gnt0, rdata0);
        end
    endtask

    task automatic test_write();
        req1 = 1; wr1 = 1; addr1 = 13'h1FFF; wdata1 = 8'h3C; mem_rdata = 8'hEE;
        for (int c = 1; c <= WAIT + 1; c++) begin
            @(negedge clk);
            checks++;
            if ({gnt0, gnt1, mem_rd, mem_wr, done1} !== 5'b01010 || mem_addr !== 13'h1FFF || mem_wdata !== 8'h3C) begin
                failures++;
                $display("FAIL write_access_c%0d: gnt=%b%b rd=%b wr=%b done1=%b addr=%h wd=%h required 01010 1fff 3c",
                         c, gnt0, gnt1, mem_rd, mem_wr, done1, mem_addr, mem_wdata);
            end
        end
        @(negedge clk);
        checks++;
        if ({done1, mem_wr, rdata1, rdata0} !== {2'b10, 8'h00, 8'hA5}) begin
            failures++;
            $display("FAIL write_done: done1=%b wr=%b rdata1=%h rdata0=%h required 1 0 00 a5",
                     done1, mem_wr, rdata1, rdata0);
        end
        req1 = 0; wr1 = 0;
        wait_idle("write");
    endtask

    task automatic test_round_robin();
        int n, cyc;
        int who [4];
        int tdone [4];
        do_reset();
        req0 = 1; req1 = 1; cpu_halt = 0;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done0 || done1) begin
                who[n]   = done1 ? 1 : 0;
                tdone[n] = cyc;
                n++;
            end
        end
        req0 = 0; req1 = 0;
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL rr_timeout: dones=%0d required 4", n);
        end else begin
            checks++;
            if (tdone[0] !== WAIT + 2) begin
                failures++;
                $display("FAIL rr_first_latency: cycle=%0d required %0d", tdone[0], WAIT + 2);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (who[i] !== (i % 2)) begin
                    failures++;
                    $display("FAIL rr_order_%0d: port=%0d required %0d", i, who[i], i % 2);
                end
                if (i > 0) begin
                    checks++;
                    if (tdone[i] - tdone[i-1] !== WAIT + 3) begin
                        failures++;
                        $display("FAIL rr_spacing_%0d: gap=%0d required %0d", i, tdone[i] - tdone[i-1], WAIT + 3);
                    end
                end
            end
        end
        wait_idle("rr");
    endtask

    task automatic test_halt_tie();
        do_reset();
        req0 = 1; req1 = 1; cpu_halt = 1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            failures++;
            $display("FAIL halt_tie: gnt=%b%b required 01", gnt0, gnt1);
        end
        req0 = 0; req1 = 0; cpu_halt = 0;
        wait_idle("halt");
        req0 = 1; req1 = 1; cpu_halt = 0;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            failures++;
            $display("FAIL rr_after_halt: gnt=%b%b required 10", gnt0, gnt1);
        end
        req0 = 0; req1 = 0;
        wait_idle("halt2");
    endtask

    task automatic test_reset_mid_access();
        req0 = 1; wr0 = 0; addr0 = 13'h00AB; mem_rdata = 8'h77;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (mem_rd !== 1'b1 || gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre: rd=%b gnt0=%b required 1 1", mem_rd, gnt0);
        end
        reset = 0;
        #1;
        checks++;
        if ({gnt0, gnt1, done0, done1, mem_rd, mem_wr, busy, mem_addr, mem_wdata, rdata0, rdata1} !== '0) begin
            failures++;
            $display("FAIL abort_outputs: gnt=%b%b done=%b%b rd=%b wr=%b busy=%b addr=%h r0=%h required all 0",
                     gnt0, gnt1, done0, done1, mem_rd, mem_wr, busy, mem_addr, rdata0);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: done0=%b busy=%b required 0 0", done0, busy);
        end
        reset = 1;
        for (int c = 1; c <= WAIT + 1; c++) begin
            @(negedge clk);
            checks++;
            if ({gnt0, mem_rd, done0} !== 3'b110 || mem_addr !== 13'h00AB) begin
                failures++;
                $display("FAIL abort_restart_c%0d: gnt0=%b rd=%b done0=%b addr=%h required 110 00ab",
                         c, gnt0, mem_rd, done0, mem_addr);
            end
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || rdata0 !== 8'h77) begin
            failures++;
            $display("FAIL abort_restart_done: done0=%b rdata0=%h required 1 77", done0, rdata0);
        end
        req0 = 0;
        wait_idle("abort");
    endtask

    task automatic test_req_drop();
        int n;
        logic seen;
        req0 = 1; wr0 = 1; addr0 = 13'h0123; wdata0 = 8'h5A;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1 || mem_wr !== 1'b1) begin
            failures++;
            $display("FAIL drop_grant: gnt0=%b wr=%b required 1 1", gnt0, mem_wr);
        end
        req0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
        seen = 0; n = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            if (done0) seen = 1;
            else if (mem_wr && (mem_addr !== 13'h0123 || mem_wdata !== 8'h5A)) begin
                failures++;
                $display("FAIL drop_bus: addr=%h wd=%h required 0123 5a", mem_addr, mem_wdata);
            end
        end
        checks++;
        if (!seen || n !== WAIT + 1) begin
            failures++;
            $display("FAIL drop_done: seen=%b after=%0d required 1 %0d", seen, n, WAIT + 1);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_no_restart: busy=%b required 0", busy);
        end
    endtask

    task automatic test_random();
        bit            m_active, m_owner, m_wr, m_last, w;
        int            m_k;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata;
        logic [DW-1:0] m_rdata [2];
        logic [7:0]    exp_ctl, act_ctl;
        do_reset();
        m_active = 0; m_owner = 0; m_wr = 0; m_last = 1; m_k = 0;
        m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            exp_ctl = {m_active && !m_owner, m_active && m_owner,
                       m_active && m_k == WAIT + 2 && !m_owner,
                       m_active && m_k == WAIT + 2 && m_owner,
                       m_active && m_k <= WAIT + 1 && !m_wr,
                       m_active && m_k <= WAIT + 1 && m_wr,
                       m_active, 1'b0};
            act_ctl = {gnt0, gnt1, done0, done1, mem_rd, mem_wr, busy, 1'b0};
            checks++;
            if (act_ctl !== exp_ctl || mem_addr !== m_addr || mem_wdata !== m_wdata ||
                rdata0 !== m_rdata[0] || rdata1 !== m_rdata[1]) begin
                failures++;
                $display("FAIL random_c%0d: ctl=%b addr=%h wd=%h r0=%h r1=%h required ctl=%b addr=%h wd=%h r0=%h r1=%h",
                         cyc, act_ctl, mem_addr, mem_wdata, rdata0, rdata1,
                         exp_ctl, m_addr, m_wdata, m_rdata[0], m_rdata[1]);
            end
            req0      = ($urandom_range(0, 2) != 0);
            req1      = ($urandom_range(0, 2) != 0);
            wr0       = $urandom_range(0, 1);
            wr1       = $urandom_range(0, 1);
            cpu_halt  = ($urandom_range(0, 3) == 0);
            addr0     = AW'($urandom);
            addr1     = AW'($urandom);
            wdata0    = DW'($urandom);
            wdata1    = DW'($urandom);
            mem_rdata = DW'($urandom);
            @(posedge clk);
            if (m_active) begin
                if (m_k == WAIT + 1 && !m_wr) m_rdata[m_owner] = mem_rdata;
                if (m_k == WAIT + 2) begin
                    m_active = 0;
                    m_last   = m_owner;
                end else begin
                    m_k++;
                end
            end else if (req0 || req1) begin
                w        = (req0 && req1) ? (cpu_halt ? 1'b1 : !m_last) : req1;
                m_owner  = w;
                m_wr     = w ? wr1 : wr0;
                m_addr   = w ? addr1 : addr0;
                m_wdata  = w ? wdata1 : wdata0;
                m_active = 1;
                m_k      = 1;
            end
        end
        drive_idle();
        wait_idle("random");
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_round_robin();
        test_halt_tie();
        test_reset_mid_access();
        test_req_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
